// File: rtl/mvau_stream_sched_if.sv
// Stream and datapath-control bundle for the MVAU issue scheduler.
// master = scheduler side, slave = activation source / datapath / sink.
interface mvau_stream_sched_if #(
   parameter int SF_T = 3,
   parameter int NF_T = 1
);
   logic                 in_v;
   logic                 in_rdy;
   logic                 out_rdy;
   logic                 out_v;
   logic                 pipe_en;
   logic                 issue;
   logic                 ib_wen;
   logic                 ib_ren;
   logic [SF_T-1:0]      ib_addr;
   logic [SF_T+NF_T:0]   wmem_addr;
   logic                 acc_clr;
   logic                 busy;

   modport master (
      input  in_v, out_rdy,
      output in_rdy, out_v, pipe_en, issue,
      output ib_wen, ib_ren, ib_addr, wmem_addr,
      output acc_clr, busy
   );

   modport slave (
      output in_v, out_rdy,
      input  in_rdy, out_v, pipe_en, issue,
      input  ib_wen, ib_ren, ib_addr, wmem_addr,
      input  acc_clr, busy
   );
endinterface

// File: rtl/mvau_stream_sched.sv
// MVAU issue scheduler: buffer fill/reuse sequencing, weight addressing,
// result token tracking and output backpressure freeze.
module mvau_stream_sched #(
   parameter int SF       = 8,
   parameter int NF       = 2,
   parameter int SF_T     = 3,
   parameter int NF_T     = 1,
   parameter int PIPE_LAT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   mvau_stream_sched_if.master bus
);
   localparam int WA = SF_T + NF_T + 1;
   localparam logic [SF_T-1:0] SF_LAST = SF_T'(SF - 1);
   localparam logic [NF_T-1:0] NF_LAST = NF_T'(NF - 1);
   localparam logic [WA-1:0]   W_MAX   = WA'(SF * NF - 1);

   typedef enum logic {
      S_FILL  = 1'b0,
      S_REUSE = 1'b1
   } state_t;

   state_t          r_state;
   logic [SF_T-1:0] r_sf;
   logic [NF_T-1:0] r_nf;
   logic [WA-1:0]   r_wmem;
   logic            r_out_v;

   logic w_pipe_en;
   logic w_issue;
   logic w_sf_last;
   logic w_last_issue;
   logic w_tok_exit;
   logic w_tok_any;

   // Stall when a result is held, and derive this cycle's issue.
   always_comb begin
      w_pipe_en    = ~(r_out_v & ~bus.out_rdy);
      w_issue      = (r_state == S_FILL) ? (bus.in_v & w_pipe_en)
                                         : w_pipe_en;
      w_sf_last    = (r_sf == SF_LAST);
      w_last_issue = w_issue & w_sf_last;
   end

   // Beat sequencer: sf/nf counters, weight address and fill/reuse state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_FILL;
         r_sf    <= '0;
         r_nf    <= '0;
         r_wmem  <= '0;
      end else if (w_issue) begin
         r_wmem <= (r_wmem == W_MAX) ? '0 : r_wmem + WA'(1);
         if (w_sf_last) begin
            r_sf <= '0;
            if (r_nf == NF_LAST) begin
               r_nf    <= '0;
               r_state <= S_FILL;
            end else begin
               r_nf    <= r_nf + NF_T'(1);
               r_state <= S_REUSE;
            end
         end else begin
            r_sf <= r_sf + SF_T'(1);
         end
      end
   end

   // Last-beat tokens; out_v is the final stage of the latency chain.
   if (PIPE_LAT == 1) begin : g_nopipe
      assign w_tok_exit = w_last_issue;
      assign w_tok_any  = 1'b0;
   end else begin : g_pipe
      logic [PIPE_LAT-2:0] r_tok;

      // Shift tokens forward on every enabled cycle.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_tok <= '0;
         end else if (w_pipe_en) begin
            r_tok[0] <= w_last_issue;
            for (int i = 1; i < PIPE_LAT - 1; i++) begin
               r_tok[i] <= r_tok[i-1];
            end
         end
      end

      assign w_tok_exit = r_tok[PIPE_LAT-2];
      assign w_tok_any  = |r_tok;
   end

   // Result valid: set by an exiting token, cleared by a handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_v <= 1'b0;
      end else if (w_pipe_en) begin
         if (w_tok_exit) begin
            r_out_v <= 1'b1;
         end else if (bus.out_rdy) begin
            r_out_v <= 1'b0;
         end
      end
   end

   assign bus.pipe_en   = w_pipe_en;
   assign bus.issue     = w_issue;
   assign bus.in_rdy    = (r_state == S_FILL) & w_pipe_en;
   assign bus.ib_wen    = (r_state == S_FILL) & w_issue;
   assign bus.ib_ren    = (r_state == S_REUSE) & w_issue;
   assign bus.ib_addr   = r_sf;
   assign bus.wmem_addr = r_wmem;
   assign bus.acc_clr   = w_issue & (r_sf == '0);
   assign bus.out_v     = r_out_v;
   assign bus.busy      = (r_state == S_REUSE) | (r_sf != '0)
                        | w_tok_any | r_out_v;
endmodule
